board_pixel_renderer: RTL and testbench

Pipelined, parametrised Tetris pixel renderer that sits between the VGA controller and the DAC outputs. Each cycle it maps one (DrawX, DrawY) pixel to RGB by combining three sources: the locked-board colour RAM, up to NUM_BLOCKS active-piece cells and a line-clear flash animation. It drives the board RAM read address itself and registers RGB with a fixed 3-cycle latency. A frame-counted flash FSM highlights rows being cleared and reports completion back to game logic.

---
 rtl/board_pixel_renderer_if.sv | 17 +
 rtl/board_pixel_renderer.sv | 252 +++++++++++++++++++++++++
 tb/tb_board_pixel_renderer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/board_pixel_renderer_if.sv
`default_nettype none
// ============================================================================
// Module      : board_pixel_renderer_if
// Description : Board colour RAM read port. The renderer drives the address
//               and the RAM returns the cell colour one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
interface board_pixel_renderer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] board_addr;
  logic [2:0]        board_color;

  modport master (output board_addr, input board_color);
  modport slave  (input board_addr, output board_color);
endinterface
`default_nettype wire

// File: rtl/board_pixel_renderer.sv
`default_nettype none
// ============================================================================
// Module      : board_pixel_renderer
// Description : Three-stage Tetris pixel renderer. Maps (DrawX, DrawY) to RGB
//               from the locked-board RAM, the active piece cells and a
//               frame-counted line-clear flash.
// Revision    : 1.0 - initial release
// ============================================================================
module board_pixel_renderer #(
  parameter int COLS         = 12,
  parameter int ROWS         = 18,
  parameter int SQ           = 26,
  parameter int X0           = 160,
  parameter int NUM_BLOCKS   = 4,
  parameter int FLASH_FRAMES = 8,
  parameter int ADDR_W       = 8
) (
  input  wire logic                    Clk,
  input  wire logic                    Reset,
  input  wire logic [9:0]              DrawX,
  input  wire logic [9:0]              DrawY,
  input  wire logic                    pixel_valid,
  input  wire logic                    frame_start,
  input  wire logic [4*NUM_BLOCKS-1:0] block_x,
  input  wire logic [5*NUM_BLOCKS-1:0] block_y,
  input  wire logic [2:0]              piece_color,
  board_pixel_renderer_if.master       ram,
  input  wire logic [ROWS-1:0]         clear_rows,
  input  wire logic                    clear_start,
  output logic                         flash_done,
  output logic [7:0]                   Red,
  output logic [7:0]                   Green,
  output logic [7:0]                   Blue
);

  localparam int X_END = X0 + COLS * SQ;
  localparam int Y_END = ROWS * SQ;
  localparam int OFF_W = (SQ > 1) ? $clog2(SQ) : 1;
  localparam int CNT_W = $clog2(FLASH_FRAMES);
  localparam int MUL_W = (ADDR_W > 10) ? ADDR_W : 10;

  typedef enum logic [2:0] {
    CLS_BLANK  = 3'd0,
    CLS_BORDER = 3'd1,
    CLS_FLASH  = 3'd2,
    CLS_GRID   = 3'd3,
    CLS_EMPTY  = 3'd4,
    CLS_PAL    = 3'd5
  } pix_class_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ---------------- Stage 0: pixel to cell coordinates ----------------
  logic              w_in_board;
  logic [9:0]        w_dx;
  logic [3:0]        w_col;
  logic [4:0]        w_row;
  logic [OFF_W-1:0]  w_ox;
  logic [OFF_W-1:0]  w_oy;
  logic [ADDR_W-1:0] w_addr;

  // Board hit test, cell split and RAM address (zero outside the board)
  always_comb begin
    w_in_board = (32'(DrawX) >= 32'(X0)) && (32'(DrawX) < 32'(X_END)) &&
                 (32'(DrawY) < 32'(Y_END));
    w_dx   = DrawX - 10'(X0);
    w_col  = 4'(w_dx / 10'(SQ));
    w_ox   = OFF_W'(w_dx % 10'(SQ));
    w_row  = 5'(DrawY / 10'(SQ));
    w_oy   = OFF_W'(DrawY % 10'(SQ));
    w_addr = '0;
    if (w_in_board) begin
      w_addr = ADDR_W'(MUL_W'(w_row) * MUL_W'(COLS) + MUL_W'(w_col));
    end
  end

  assign ram.board_addr = w_addr;

  // ---------------- Stage 1 registers ----------------
  logic             s1_valid_q;
  logic             s1_in_board_q;
  logic [3:0]       s1_col_q;
  logic [4:0]       s1_row_q;
  logic [OFF_W-1:0] s1_ox_q;
  logic [OFF_W-1:0] s1_oy_q;

  // Capture cell coordinates alongside the RAM read in flight
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid_q    <= 1'b0;
      s1_in_board_q <= 1'b0;
      s1_col_q      <= '0;
      s1_row_q      <= '0;
      s1_ox_q       <= '0;
      s1_oy_q       <= '0;
    end else begin
      s1_valid_q    <= pixel_valid;
      s1_in_board_q <= w_in_board;
      s1_col_q      <= w_col;
      s1_row_q      <= w_row;
      s1_ox_q       <= w_ox;
      s1_oy_q       <= w_oy;
    end
  end

  // ---------------- Flash FSM ----------------
  state_t            state_q, state_d;
  logic [ROWS-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Flash controller state, mask and frame counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the empty-mask decision is made on the latched mask,
  // which is why a zero-row clear completes two cycles after clear_start
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    flash_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          mask_d  = clear_rows;
          cnt_d   = '0;
          state_d = ST_FLASH;
        end
      end
      ST_FLASH: begin
        if (mask_q == '0) begin
          state_d = ST_DONE;
        end else if (frame_start) begin
          if (cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        flash_done = 1'b1;
        mask_d     = '0;
        cnt_d      = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- Stage 2: colour class resolution ----------------
  logic [NUM_BLOCKS-1:0] w_blk_hit;
  logic                  w_row_hit;
  logic                  w_phase;

  for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_blk
    assign w_blk_hit[gi] = (block_x[4*gi +: 4] == s1_col_q) &&
                           (block_y[5*gi +: 5] == s1_row_q);
  end

  assign w_row_hit = |(mask_q & (ROWS'(1) << s1_row_q));
  assign w_phase   = (state_q == ST_FLASH) && cnt_q[0];

  pix_class_t s2_cls_q, s2_cls_d;
  logic [2:0] s2_idx_q, s2_idx_d;

  // Priority resolution: blank, border, flash, piece, board, grid, empty
  always_comb begin
    s2_cls_d = CLS_EMPTY;
    s2_idx_d = '0;
    if (!s1_valid_q) begin
      s2_cls_d = CLS_BLANK;
    end else if (!s1_in_board_q) begin
      s2_cls_d = CLS_BORDER;
    end else if (w_row_hit && w_phase) begin
      s2_cls_d = CLS_FLASH;
    end else if (|w_blk_hit) begin
      s2_cls_d = CLS_PAL;
      s2_idx_d = piece_color;
    end else if (ram.board_color != 3'd0) begin
      s2_cls_d = CLS_PAL;
      s2_idx_d = ram.board_color;
    end else if ((s1_ox_q == '0) || (s1_oy_q == '0)) begin
      s2_cls_d = CLS_GRID;
    end
  end

  // Register the resolved class and palette index
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s2_cls_q <= CLS_BLANK;
      s2_idx_q <= '0;
    end else begin
      s2_cls_q <= s2_cls_d;
      s2_idx_q <= s2_idx_d;
    end
  end

  // ---------------- Stage 3: palette lookup ----------------
  logic [23:0] rgb_d, rgb_q;

  // Fixed palette translation of class/index to 24-bit colour
  always_comb begin
    rgb_d = 24'h000000;
    case (s2_cls_q)
      CLS_BORDER: rgb_d = 24'hFF5500;
      CLS_FLASH:  rgb_d = 24'hFFFFFF;
      CLS_GRID:   rgb_d = 24'h202020;
      CLS_PAL: begin
        case (s2_idx_q)
          3'd1:    rgb_d = 24'h00FFFF;
          3'd2:    rgb_d = 24'hFFFF00;
          3'd3:    rgb_d = 24'hA000F0;
          3'd4:    rgb_d = 24'h00FF00;
          3'd5:    rgb_d = 24'hFF0000;
          3'd6:    rgb_d = 24'h0000FF;
          3'd7:    rgb_d = 24'hFF8000;
          default: rgb_d = 24'h000000;
        endcase
      end
      default: rgb_d = 24'h000000;
    endcase
  end

  // Output colour register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign Red   = rgb_q[23:16];
  assign Green = rgb_q[15:8];
  assign Blue  = rgb_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_board_pixel_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_pixel_renderer
// Description : Scoreboard bench for board_pixel_renderer with a synchronous
//               board RAM model and directed pixel / flash / reset vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_pixel_renderer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        pixel_valid, frame_start;
  logic [15:0] block_x;
  logic [19:0] block_y;
  logic [2:0]  piece_color;
  logic [17:0] clear_rows;
  logic        clear_start;
  logic        flash_done;
  logic [7:0]  Red, Green, Blue;

  board_pixel_renderer_if #(.ADDR_W(8)) ram_if ();

  board_pixel_renderer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .block_x     (block_x),
    .block_y     (block_y),
    .piece_color (piece_color),
    .ram         (ram_if),
    .clear_rows  (clear_rows),
    .clear_start (clear_start),
    .flash_done  (flash_done),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue)
  );

  always #5 Clk = ~Clk;

  // Board RAM model: one-cycle read latency
  logic [2:0] mem [0:255];
  always @(posedge Clk) ram_if.board_color <= mem[ram_if.board_addr];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [23:0] exp_q [$];
  int          id_q  [$];
  logic        chk_now = 1'b0;
  logic [2:0]  trk = 3'b000;
  logic [23:0] mon_e;
  int          mon_id;
  logic [23:0] pal [1:7];

  // Track which issued pixels are checked; they surface 3 edges later
  always @(posedge Clk or posedge Reset) begin
    if (Reset) trk <= 3'b000;
    else       trk <= {trk[1:0], chk_now};
  end

  always @(posedge Clk) if (flash_done) done_cnt++;

  // Monitor: pop expected colour when a tracked pixel reaches the output
  always @(negedge Clk) begin
    if (trk[2]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got %h with no expected entry", {Red, Green, Blue});
      end else begin
        mon_e  = exp_q.pop_front();
        mon_id = id_q.pop_front();
        if ({Red, Green, Blue} !== mon_e) begin
          errors++;
          $display("FAIL pix%0d: got %h expected %h", mon_id, {Red, Green, Blue}, mon_e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic v, input logic [23:0] e, input int id);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    pixel_valid = v;
    chk_now = 1'b1;
    exp_q.push_back(e);
    id_q.push_back(id);
    @(negedge Clk);
    chk_now = 1'b0;
    pixel_valid = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic frame();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic clr(input logic [17:0] rows);
    @(negedge Clk);
    clear_rows  = rows;
    clear_start = 1'b1;
    @(negedge Clk);
    clear_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0;
    pal[1] = 24'h00FFFF; pal[2] = 24'hFFFF00; pal[3] = 24'hA000F0;
    pal[4] = 24'h00FF00; pal[5] = 24'hFF0000; pal[6] = 24'h0000FF;
    pal[7] = 24'hFF8000;
    for (int i = 0; i < 256; i++) mem[i] = 3'd0;
    Reset = 1'b1;
    DrawX = 10'd100; DrawY = 10'd50; pixel_valid = 1'b1; frame_start = 1'b0;
    block_x = {4{4'hF}}; block_y = {4{5'd31}}; piece_color = 3'd0;
    clear_rows = '0; clear_start = 1'b0;

    // Reset state and black output for the first cycles after release
    repeat (3) @(negedge Clk);
    check("reset_rgb", 32'({Red, Green, Blue}), 32'h0);
    check("reset_done", 32'(flash_done), 32'h0);
    Reset = 1'b0;
    @(negedge Clk); check("post_rst_c1", 32'({Red, Green, Blue}), 32'h0);
    @(negedge Clk); check("post_rst_c2", 32'({Red, Green, Blue}), 32'h0);
    @(negedge Clk); check("post_rst_c3", 32'({Red, Green, Blue}), 32'hFF5500);
    pixel_valid = 1'b0;

    // Combinational RAM address
    @(negedge Clk); DrawX = 10'd217; DrawY = 10'd31; #1;
    check("addr_14", 32'(ram_if.board_addr), 32'd14);
    DrawX = 10'd100; #1;
    check("addr_out", 32'(ram_if.board_addr), 32'd0);

    // Basic classes on an empty board
    pix(100, 50, 1'b1, 24'hFF5500, 1);
    pix(161, 27, 1'b1, 24'h000000, 2);
    pix(160, 27, 1'b1, 24'h202020, 3);

    // Board colour, then piece overriding it, then blanking
    mem[14] = 3'd3;
    pix(217, 31, 1'b1, 24'hA000F0, 4);
    block_x[3:0] = 4'd2; block_y[4:0] = 5'd1; piece_color = 3'd5;
    pix(217, 31, 1'b1, 24'hFF0000, 5);
    pix(217, 31, 1'b0, 24'h000000, 6);
    block_x[3:0] = 4'hF; block_y[4:0] = 5'd31;
    mem[14] = 3'd0;

    // Edges of the board and a piece in the last cell via block 3
    pix(300, 470, 1'b1, 24'hFF5500, 7);
    pix(159, 100, 1'b1, 24'hFF5500, 8);
    pix(472, 467, 1'b1, 24'hFF5500, 9);
    pix(471, 467, 1'b1, 24'h000000, 10);
    block_x[15:12] = 4'd11; block_y[19:15] = 5'd17; piece_color = 3'd7;
    pix(471, 467, 1'b1, 24'hFF8000, 11);
    block_x[15:12] = 4'hF; block_y[19:15] = 5'd31;

    // Whole palette through board RAM, row 0
    for (int c = 1; c <= 7; c++) begin
      mem[c - 1] = 3'(c);
      pix(160 + (c - 1) * 26 + 3, 3, 1'b1, pal[c], 20 + c);
    end
    for (int c = 0; c < 7; c++) mem[c] = 3'd0;

    // Line-clear flash of row 17; a second clear_start is ignored
    clr(18'h20000);
    pix(295, 447, 1'b1, 24'h000000, 30);
    for (int f = 1; f <= 8; f++) begin
      frame();
      if (f == 8) begin
        check("flash_done_hi", 32'(flash_done), 32'h1);
        @(negedge Clk);
        check("flash_done_lo", 32'(flash_done), 32'h0);
      end else begin
        if (f == 2) clr(18'h00001);
        pix(295, 447, 1'b1, (f % 2 == 1) ? 24'hFFFFFF : 24'h000000, 30 + f);
        if (f == 3) pix(295, 5, 1'b1, 24'h000000, 40);
      end
    end
    pix(295, 447, 1'b1, 24'h000000, 41);
    check("done_count_flash", 32'(done_cnt), 32'd1);

    // Zero-mask clear: done two cycles after clear_start
    @(negedge Clk);
    clear_rows = '0; clear_start = 1'b1;
    @(negedge Clk); clear_start = 1'b0;
    check("zm_c1", 32'(flash_done), 32'h0);
    @(negedge Clk); check("zm_c2", 32'(flash_done), 32'h1);
    @(negedge Clk); check("zm_c3", 32'(flash_done), 32'h0);
    pix(295, 447, 1'b1, 24'h000000, 42);

    // Asynchronous reset in the middle of a flash (cnt = 4)
    clr(18'h20000);
    repeat (4) frame();
    pix(295, 447, 1'b1, 24'h000000, 43);
    d0 = done_cnt;
    @(negedge Clk); DrawX = 10'd100; DrawY = 10'd50; pixel_valid = 1'b1;
    repeat (3) @(negedge Clk);
    check("pre_reset_rgb", 32'({Red, Green, Blue}), 32'hFF5500);
    #2 Reset = 1'b1;
    #1 check("async_reset_rgb", 32'({Red, Green, Blue}), 32'h0);
    check("async_reset_done", 32'(flash_done), 32'h0);
    @(negedge Clk); pixel_valid = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (10) @(negedge Clk);
    check("no_done_after_reset", 32'(done_cnt), 32'(d0));
    frame();
    pix(295, 447, 1'b1, 24'h000000, 44);
    frame();
    pix(295, 447, 1'b1, 24'h000000, 45);

    repeat (5) @(negedge Clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("done_count_total", 32'(done_cnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
